// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and codes for the pipeline hazard controller.
// State encoding, forwarding selects and branch-stage constants.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DATA = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX source register.
// The nearer producer (EX/MEM) wins over MEM/WB; x0 never forwards.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      fwd
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_regwrite && (mem_rd != '0)
                     && (mem_rd == ex_rs);
  assign w_wb_hit  = wb_regwrite && (wb_rd != '0)
                     && (wb_rd == ex_rs);

  always_comb begin
    fwd = FWD_RF;
    if (w_mem_hit)
      fwd = FWD_EXMEM;
    else if (w_wb_hit)
      fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for a 5-stage core sharing one
// memory port between fetch and data with MEM_LAT-cycle accesses.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MEM_LAT  = 1,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_regwrite,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_req,
  input  logic             redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAST = LW'(MEM_LAT - 1);
  localparam logic BR_M = (BR_STAGE == BR_MEM);

  state_e           r_state;
  logic [LW-1:0]    r_lat;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  logic       w_last;
  logic       w_lu;
  logic       w_adv;
  logic       w_rel;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic [1:0] w_fa;
  logic [1:0] w_fb;

  assign w_last = (r_lat == LAST);
  assign w_lu   = ex_memread && (ex_rd != '0)
                  && ((id_use1 && (id_rs1 == ex_rd))
                   || (id_use2 && (id_rs2 == ex_rd)));
  assign w_adv  = (r_state == RUN) && w_last && !mem_req;
  assign w_rel  = (r_state == DATA) && w_last;

  assign w_stall_inc = !w_adv || (!redirect && w_lu);
  assign w_flush_inc = (w_adv || w_rel) && redirect;

  fwd_select #(.RA_W(RA_W)) u_fwd_a (
    .ex_rs       (ex_rs1),
    .mem_regwrite(mem_regwrite),
    .mem_rd      (mem_rd),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .fwd         (w_fa)
  );

  fwd_select #(.RA_W(RA_W)) u_fwd_b (
    .ex_rs       (ex_rs2),
    .mem_regwrite(mem_regwrite),
    .mem_rd      (mem_rd),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .fwd         (w_fb)
  );

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_sel      = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    if (!rst) begin
      mem_sel = (r_state == DATA);
      fwd_a   = w_fa;
      fwd_b   = w_fb;
      if (w_adv) begin
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if (redirect) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = BR_M;
        end else if (w_lu) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end else if (w_rel) begin
        // No fetch happened during the data access: IF/ID gets a bubble.
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        if (redirect) begin
          pc_en        = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = BR_M;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_lat   <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (mem_req) begin
            r_state <= DATA;
            r_lat   <= '0;
          end else if (w_last) begin
            r_lat <= '0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        DATA: begin
          if (w_last) begin
            r_state <= RUN;
            r_lat   <= '0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
          r_lat   <= '0;
        end
      endcase
      if (w_stall_inc && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      if (w_flush_inc && (r_flush != '1))
        r_flush <= r_flush + 1'b1;
    end
  end

  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random checks of two controller configurations
// against a cycle-level reference model of the port-sharing rules.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, ex_memread, mem_regwrite, wb_regwrite;
  logic mem_req, redirect;

  logic [12:0] o1, o3;
  logic [31:0] s1, f1;
  logic [3:0]  s3, f3;

  int ncmp = 0;
  int nerr = 0;

  // Reference state: in a data access?, cycles elapsed in access, counts.
  bit    m_data[2];
  int    m_k[2];
  longint m_st[2];
  longint m_fl[2];
  int    Ls[2] = '{1, 3};
  int    Bs[2] = '{2, 3};
  int    Ws[2] = '{32, 4};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .MEM_LAT(1), .BR_STAGE(2), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .redirect(redirect),
    .pc_en(o1[12]), .if_id_en(o1[11]), .id_ex_en(o1[10]),
    .ex_mem_en(o1[9]), .mem_wb_en(o1[8]),
    .if_id_flush(o1[7]), .id_ex_flush(o1[6]), .ex_mem_flush(o1[5]),
    .mem_sel(o1[4]), .fwd_a(o1[3:2]), .fwd_b(o1[1:0]),
    .stall_cnt(s1), .flush_cnt(f1)
  );

  pipe_hazard_ctrl #(.RA_W(5), .MEM_LAT(3), .BR_STAGE(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .redirect(redirect),
    .pc_en(o3[12]), .if_id_en(o3[11]), .id_ex_en(o3[10]),
    .ex_mem_en(o3[9]), .mem_wb_en(o3[8]),
    .if_id_flush(o3[7]), .id_ex_flush(o3[6]), .ex_mem_flush(o3[5]),
    .mem_sel(o3[4]), .fwd_a(o3[3:2]), .fwd_b(o3[1:0]),
    .stall_cnt(s3), .flush_cnt(f3)
  );

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    return ex_memread && ex_rd != 0 &&
           ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [12:0] ref_ctrl(int d);
    logic pc, ifid, idex, exm, mwb, fif, fid, fexm, sel;
    bit done;
    {pc, ifid, idex, exm, mwb, fif, fid, fexm, sel} = '0;
    if (rst) return 13'd0;
    done = (m_k[d] + 1 == Ls[d]);
    if (!m_data[d]) begin
      if (done && !mem_req) begin
        {idex, exm, mwb} = 3'b111;
        if (redirect) begin
          {pc, ifid, fif, fid} = 4'b1111;
          fexm = (Bs[d] == 3);
        end else if (ref_lu()) begin
          fid = 1'b1;
        end else begin
          {pc, ifid} = 2'b11;
        end
      end
    end else begin
      sel = 1'b1;
      if (done) begin
        {idex, exm, mwb, fif} = 4'b1111;
        if (redirect) begin
          {pc, fid} = 2'b11;
          fexm = (Bs[d] == 3);
        end
      end
    end
    return {pc, ifid, idex, exm, mwb, fif, fid, fexm, sel,
            ref_fwd(ex_rs1), ref_fwd(ex_rs2)};
  endfunction

  task automatic ref_reset(int d);
    m_data[d] = 0; m_k[d] = 0; m_st[d] = 0; m_fl[d] = 0;
  endtask

  task automatic bump(inout longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
    if (c < mx) c = c + 1;
  endtask

  task automatic ref_update(int d);
    bit done;
    if (rst) begin
      ref_reset(d);
      return;
    end
    done = (m_k[d] + 1 == Ls[d]);
    if (m_data[d]) begin
      bump(m_st[d], Ws[d]);
      if (done && redirect) bump(m_fl[d], Ws[d]);
      if (done) begin m_data[d] = 0; m_k[d] = 0; end
      else m_k[d] = m_k[d] + 1;
    end else if (mem_req) begin
      bump(m_st[d], Ws[d]);
      m_data[d] = 1; m_k[d] = 0;
    end else if (done) begin
      if (redirect) bump(m_fl[d], Ws[d]);
      else if (ref_lu()) bump(m_st[d], Ws[d]);
      m_k[d] = 0;
    end else begin
      bump(m_st[d], Ws[d]);
      m_k[d] = m_k[d] + 1;
    end
  endtask

  task automatic step(string tag);
    logic [12:0] e1, e3;
    if (rst) begin ref_reset(0); ref_reset(1); end
    @(negedge clk);
    e1 = ref_ctrl(0);
    e3 = ref_ctrl(1);
    ncmp++;
    assert (o1 === e1) else begin
      nerr++; $error("FAIL %s u1.ctrl got %b exp %b", tag, o1, e1);
    end
    ncmp++;
    assert (o3 === e3) else begin
      nerr++; $error("FAIL %s u3.ctrl got %b exp %b", tag, o3, e3);
    end
    ncmp++;
    assert (s1 === 32'(m_st[0])) else begin
      nerr++; $error("FAIL %s u1.stall got %0d exp %0d", tag, s1, m_st[0]);
    end
    ncmp++;
    assert (f1 === 32'(m_fl[0])) else begin
      nerr++; $error("FAIL %s u1.flush got %0d exp %0d", tag, f1, m_fl[0]);
    end
    ncmp++;
    assert (s3 === 4'(m_st[1])) else begin
      nerr++; $error("FAIL %s u3.stall got %0d exp %0d", tag, s3, m_st[1]);
    end
    ncmp++;
    assert (f3 === 4'(m_fl[1])) else begin
      nerr++; $error("FAIL %s u3.flush got %0d exp %0d", tag, f3, m_fl[1]);
    end
    ref_update(0);
    ref_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, ex_memread, mem_regwrite, wb_regwrite} = '0;
    {mem_req, redirect} = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // lw x5 ; add x6,x5,x1
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
    id_rs2 = 1; id_use2 = 1;
    step("loaduse");
    ncmp++;
    assert (s1 === 32'd1) else begin
      nerr++; $error("FAIL lu_cnt u1.stall got %0d exp 1", s1);
    end
    clear_in();
    ex_rs1 = 5; ex_rs2 = 1; wb_regwrite = 1; wb_rd = 5;
    step("fwd_wb");

    // add x5 ; sub x7,x5,x5
    clear_in();
    mem_regwrite = 1; mem_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    wb_regwrite = 1; wb_rd = 5;
    step("fwd_mem");
    mem_rd = 0; wb_rd = 0;
    step("fwd_x0");

    // redirect alone, then redirect with a load-use
    clear_in();
    redirect = 1;
    repeat (3) step("redir");
    ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use2 = 1;
    repeat (3) step("redir_lu");

    // data access held, redirect arriving mid-freeze
    clear_in();
    mem_req = 1;
    repeat (2) step("data");
    redirect = 1;
    repeat (3) step("data_redir");
    clear_in();
    repeat (3) step("run");

    // reset in the second cycle of a 3-cycle access
    rst = 1; step("rst_a");
    rst = 0;
    mem_req = 1; step("to_data");
    step("data_c1");
    rst = 1; step("rst_mid");
    rst = 0; mem_req = 0;
    step("post_rst");
    step("post_rst2");

    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rs1       = 5'($urandom_range(0, 3));
      ex_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      id_use1      = 1'($urandom_range(0, 1));
      id_use2      = 1'($urandom_range(0, 1));
      ex_memread   = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      mem_req      = ($urandom_range(0, 3) == 0);
      redirect     = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
